if_stage: RTL

Instruction-fetch stage of the pipelined MIPS-subset CPU: holds the program counter, drives the instruction-memory address, computes the next PC (sequential or branch-redirected), and loads the IF/ID pipeline register consumed by the decode/control stage. Branches resolve in ID, and the decode stage returns the taken decision and immediate to this block. There is no branch delay slot: a taken branch squashes the instruction being fetched. Stall and flush inputs come from the hazard logic.

---
 rtl/if_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory
// combinationally, picks sequential or branch-redirected next PC and
// loads the IF/ID pipeline register for the decode stage.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] id_imm16,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  // Word-scaled, sign-extended branch displacement.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
    br_offset = $signed({{14{imm[15]}}, imm, 2'b00});
  endfunction

  logic [31:0]        r_pc;
  logic [31:0]        r_ifid_inst;
  logic [31:0]        r_ifid_pc4;
  logic               r_ifid_valid;
  logic [31:0]        r_fetch_count;

  logic [31:0]        w_pc_plus4;
  logic signed [31:0] w_br_offset;
  logic [31:0]        w_br_target;
  logic               w_take;

  // Next-PC candidates and the effective branch decision; a bubble in
  // IF/ID or a stalled pipe can never redirect.
  always_comb begin
    w_pc_plus4  = r_pc + 32'd4;
    w_br_offset = br_offset(id_imm16);
    w_br_target = r_ifid_pc4 + $unsigned(w_br_offset);
    w_take      = branch_taken & r_ifid_valid & ~stall;
  end

  // PC and IF/ID update: stall > taken branch > flush > normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_ifid_inst   <= 32'd0;
      r_ifid_pc4    <= 32'd0;
      r_ifid_valid  <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (!stall) begin
      if (w_take) begin
        // Squash the instruction being fetched; no delay slot.
        r_pc         <= w_br_target;
        r_ifid_inst  <= 32'd0;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
      end else if (flush) begin
        r_pc         <= w_pc_plus4;
        r_ifid_inst  <= 32'd0;
        r_ifid_pc4   <= 32'd0;
        r_ifid_valid <= 1'b0;
      end else begin
        r_pc          <= w_pc_plus4;
        r_ifid_inst   <= imem_data;
        r_ifid_pc4    <= w_pc_plus4;
        r_ifid_valid  <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign ifid_inst   = r_ifid_inst;
  assign ifid_pc4    = r_ifid_pc4;
  assign ifid_valid  = r_ifid_valid;
  assign fetch_count = r_fetch_count;

endmodule
